csa_operand_feeder: RTL and testbench
=====================================

Name: csa_operand_feeder

Overview:
- Producer-side driver for the carry-save accumulator's iAccumulate/iTerminate/oReady/oDone handshake.
- Buffers incoming operands in a FIFO and issues them one per cycle as accumulate pulses.
- After the operand tagged last, waits a settle interval, pulses terminate and waits for done.
- Reports the per-batch sum: the accumulator is never cleared between batches, so the feeder subtracts the previous cumulative result.

Parameters:
INPUT_LENGTH, 16, operand width
OUTPUT_LENGTH, 32, accumulator result width
DEPTH, 8, FIFO entries, power of 2, >=2
SETTLE_CYCLES, 2, idle cycles between last accumulate pulse and terminate pulse, >=1

Ports:
iClk  in  1  clock
iRst  in  1  synchronous reset, active-high; shared with accumulator
iData  in  INPUT_LENGTH  operand
iLast  in  1  operand is final of batch
iValid  in  1  operand valid
oReady  out  1  FIFO not full; push when iValid&oReady
oAccA  out  INPUT_LENGTH  operand to accumulator
oAccumulate  out  1  one-cycle accumulate pulse
oTerminate  out  1  one-cycle terminate pulse
iAccReady  in  1  accumulator ready
iAccDone  in  1  accumulator done (one cycle)
iAccRes  in  OUTPUT_LENGTH  accumulator cumulative result
oSum  out  OUTPUT_LENGTH  per-batch sum
oSumValid  out  1  one-cycle pulse, oSum updated
oBusy  out  1  high in any state except FEED with FIFO empty

Behaviour:
- Reset: FIFO emptied; rPrev=0; FSM=s_FEED.
- Reset output values: oReady=0 during reset, 1 the cycle after. oAccA=0, oAccumulate=0, oTerminate=0, oSum=0, oSumValid=0, oBusy=0.
- Reset mid-batch discards all buffered and in-flight operands; no oSumValid is produced for that batch.
- All outputs are registered.
- FIFO: entries are {last,data}; read/write pointers are log2(DEPTH)+1 bits and wrap.
  - Full when the MSBs of the pointers differ and the remaining bits are equal; empty when the pointers are equal.
  - A simultaneous push and pop when full is allowed; the push is accepted only if oReady was high that cycle.
  - A push and pop in the same cycle leaves the occupancy unchanged.
- s_FEED:
  - If the FIFO is not empty and iAccReady=1: pop the head; next cycle oAccumulate=1 and oAccA=data.
  - Back-to-back pops are allowed, one per cycle.
  - If the popped entry has last=1: load the settle counter with SETTLE_CYCLES and go to s_SETTLE.
  - Otherwise oAccumulate=0 and oAccA=0.
- s_SETTLE: no pops; decrement the counter; at 0, go to s_TERM.
- s_TERM: when iAccReady=1, assert oTerminate for exactly one cycle, then go to s_WAIT.
- s_WAIT:
  - No pops, but pushes are still accepted.
  - On iAccDone=1: oSum <= iAccRes - rPrev (mod 2^OUTPUT_LENGTH), rPrev <= iAccRes, oSumValid=1 for one cycle, go to s_FEED.
  - oSum holds its value until the next batch completes.
- oAccumulate and oTerminate are never high in the same cycle.
- Neither pulse is issued while iAccReady=0.
- Batch size is at least 1, because iLast travels with an operand.
- Batch sums wrap modulo 2^OUTPUT_LENGTH; the subtraction handles a wrap of the cumulative value correctly.
- Latency, one-operand batch with empty FIFO: push at cycle t, accumulate pulse at t+2, terminate at t+3+SETTLE_CYCLES. oSumValid is one cycle after iAccDone.

Optional Feature:
- Macro CSA_FEEDER_OVF_EN.
- When defined:
  - Adds output oOverflow (1 bit, reset 0).
  - A per-batch operand counter increments on each pop and clears on oSumValid.
  - oOverflow is set together with oSumValid when the batch count exceeds 2^(OUTPUT_LENGTH-INPUT_LENGTH), the no-wrap bound.
  - oOverflow is cleared at the next oSumValid if that batch is within the bound.
- When undefined: no counter and no port.

Test Plan:
- Push 5,7,9(last) with the accumulator model attached -> three oAccumulate pulses on consecutive cycles, then oTerminate SETTLE_CYCLES+1 cycles later; oSum=21 with oSumValid for exactly one cycle.
- Next batch 100,200(last) -> oSum=300, not 321; rPrev=321.
- Hold iAccReady=0 and push 9 operands with DEPTH=8 -> oReady=0 after 8 accepts and the 9th is held. Release iAccReady -> all 8 issue in FIFO order and the 9th is accepted once space frees.
- Set rPrev=0xFFFFFFF0 via a prior batch, then run a batch of sum 0x20 so the cumulative value wraps to 0x10 -> oSum=0x00000020.
- Assert iRst in s_SETTLE after 2 pulses -> all outputs reset, no oSumValid; a following batch 3(last) gives oSum=3.
- CSA_FEEDER_OVF_EN with INPUT_LENGTH=4, OUTPUT_LENGTH=6: a batch of 5 operands of 15 -> oOverflow=1. A following batch of 2 operands -> oOverflow=0.

Source files
------------

// File: rtl/csa_operand_feeder_if.sv
// Accumulator-side handshake bundle: the feeder drives it as master, the
// carry-save accumulator sits on the slave side.
interface csa_operand_feeder_if #(
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 32
);
  logic [INPUT_LENGTH-1:0]  oAccA;
  logic                     oAccumulate;
  logic                     oTerminate;
  logic                     iAccReady;
  logic                     iAccDone;
  logic [OUTPUT_LENGTH-1:0] iAccRes;

  modport master (
    output oAccA, oAccumulate, oTerminate,
    input  iAccReady, iAccDone, iAccRes
  );

  modport slave (
    input  oAccA, oAccumulate, oTerminate,
    output iAccReady, iAccDone, iAccRes
  );
endinterface

// File: rtl/csa_operand_feeder.sv
// Buffers operands and feeds them to the carry-save accumulator, then reports
// per-batch sums. Define CSA_FEEDER_OVF_EN to add the oOverflow batch-length flag.
module csa_operand_feeder #(
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 32,
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [INPUT_LENGTH-1:0]  iData,
  input  logic                     iLast,
  input  logic                     iValid,
  output logic                     oReady,
  csa_operand_feeder_if.master     acc,
  output logic [OUTPUT_LENGTH-1:0] oSum,
  output logic                     oSumValid,
  output logic                     oBusy
`ifdef CSA_FEEDER_OVF_EN
  ,
  output logic                     oOverflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {s_FEED, s_SETTLE, s_TERM, s_WAIT} state_t;

  state_t                   r_state;
  logic [INPUT_LENGTH:0]    r_mem [DEPTH];
  logic [PW-1:0]            r_wrPtr;
  logic [PW-1:0]            r_rdPtr;
  logic                     r_ready;
  logic [SW-1:0]            r_settle;
  logic [INPUT_LENGTH-1:0]  r_accA;
  logic                     r_accumulate;
  logic                     r_terminate;
  logic [OUTPUT_LENGTH-1:0] r_prev;
  logic [OUTPUT_LENGTH-1:0] r_sum;
  logic                     r_sumValid;
  logic                     r_busy;

  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic [INPUT_LENGTH:0]    w_head;
  logic [PW-1:0]            w_wrPtrNext;
  logic [PW-1:0]            w_rdPtrNext;
  logic                     w_fullNext;
  logic                     w_emptyNext;

  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_push      = iValid && r_ready;
  assign w_pop       = (r_state == s_FEED) && !w_empty && acc.iAccReady;
  assign w_head      = r_mem[r_rdPtr[AW-1:0]];
  assign w_wrPtrNext = r_wrPtr + PW'(w_push);
  assign w_rdPtrNext = r_rdPtr + PW'(w_pop);
  assign w_fullNext  = (w_wrPtrNext[PW-1] != w_rdPtrNext[PW-1]) &&
                       (w_wrPtrNext[AW-1:0] == w_rdPtrNext[AW-1:0]);
  assign w_emptyNext = (w_wrPtrNext == w_rdPtrNext);

  // oReady is registered from the post-update occupancy so it never lags a fill
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ready <= 1'b0;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      r_rdPtr <= w_rdPtrNext;
      r_ready <= !w_fullNext;
    end
  end

  always_ff @(posedge iClk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= {iLast, iData};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= s_FEED;
      r_settle     <= '0;
      r_accA       <= '0;
      r_accumulate <= 1'b0;
      r_terminate  <= 1'b0;
      r_prev       <= '0;
      r_sum        <= '0;
      r_sumValid   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_accA       <= '0;
      r_accumulate <= 1'b0;
      r_terminate  <= 1'b0;
      r_sumValid   <= 1'b0;
      r_busy       <= 1'b1;
      case (r_state)
        s_FEED: begin
          r_busy <= !w_emptyNext;
          if (w_pop) begin
            r_accumulate <= 1'b1;
            r_accA       <= w_head[INPUT_LENGTH-1:0];
            if (w_head[INPUT_LENGTH]) begin
              r_settle <= SW'(SETTLE_CYCLES);
              r_state  <= s_SETTLE;
              r_busy   <= 1'b1;
            end
          end
        end
        s_SETTLE: begin
          r_settle <= r_settle - SW'(1);
          if (r_settle == SW'(1)) r_state <= s_TERM;
        end
        s_TERM: begin
          if (acc.iAccReady) begin
            r_terminate <= 1'b1;
            r_state     <= s_WAIT;
          end
        end
        s_WAIT: begin
          // The accumulator is never cleared, so the batch sum is the delta
          if (acc.iAccDone) begin
            r_sum      <= acc.iAccRes - r_prev;
            r_prev     <= acc.iAccRes;
            r_sumValid <= 1'b1;
            r_state    <= s_FEED;
            r_busy     <= !w_emptyNext;
          end
        end
        default: r_state <= s_FEED;
      endcase
    end
  end

`ifdef CSA_FEEDER_OVF_EN
  localparam int CW = OUTPUT_LENGTH - INPUT_LENGTH + 2;
  localparam logic [CW-1:0] OVF_BOUND = CW'(1) << (OUTPUT_LENGTH - INPUT_LENGTH);

  logic [CW-1:0] r_batchCnt;
  logic          r_overflow;

  // Counter saturates one past the no-wrap bound, which is all the flag needs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_batchCnt <= '0;
      r_overflow <= 1'b0;
    end else if ((r_state == s_WAIT) && acc.iAccDone) begin
      r_overflow <= (r_batchCnt > OVF_BOUND);
      r_batchCnt <= '0;
    end else if (w_pop && (r_batchCnt <= OVF_BOUND)) begin
      r_batchCnt <= r_batchCnt + CW'(1);
    end
  end

  assign oOverflow = r_overflow;
`endif

  assign oReady          = r_ready;
  assign acc.oAccA       = r_accA;
  assign acc.oAccumulate = r_accumulate;
  assign acc.oTerminate  = r_terminate;
  assign oSum            = r_sum;
  assign oSumValid       = r_sumValid;
  assign oBusy           = r_busy;

endmodule

// File: tb/tb_csa_operand_feeder.sv
// Randomized bench for csa_operand_feeder with a behavioural accumulator and a
// scoreboard of expected operand order and per-batch sums.
module tb_csa_operand_feeder;

  localparam int IL     = 16;
  localparam int OL     = 32;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 2;

  logic          iClk = 1'b0;
  logic          iRst;
  logic [IL-1:0] iData;
  logic          iLast;
  logic          iValid;
  logic          oReady;
  logic [OL-1:0] oSum;
  logic          oSumValid;
  logic          oBusy;
`ifdef CSA_FEEDER_OVF_EN
  logic          oOverflow;
`endif

  csa_operand_feeder_if #(.INPUT_LENGTH(IL), .OUTPUT_LENGTH(OL)) accBus ();

  csa_operand_feeder #(
    .INPUT_LENGTH(IL), .OUTPUT_LENGTH(OL), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iData(iData),
    .iLast(iLast),
    .iValid(iValid),
    .oReady(oReady),
    .acc(accBus),
    .oSum(oSum),
    .oSumValid(oSumValid),
    .oBusy(oBusy)
`ifdef CSA_FEEDER_OVF_EN
    ,
    .oOverflow(oOverflow)
`endif
  );

  always #5 iClk = ~iClk;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [OL-1:0] expData[$];
  logic [OL-1:0] expSums[$];
  logic [OL-1:0] runSum = '0;
  logic [OL-1:0] accVal = '0;
  logic [OL-1:0] accBias = '0;
  bit            accReadyRand = 1'b0;
  logic          accReadyForce = 1'b1;
  int            doneDelay = 0;
  bit            checkSettle = 1'b0;
  int            lastAccCyc = -100;
  int            pushCyc = 0;
  bit            prevSumValid = 1'b0;
  int            sumCount = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [OL-1:0] observed,
                             input logic [OL-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Behavioural carry-save accumulator: cumulative, only cleared by reset
  initial begin
    accBus.iAccReady = 1'b0;
    accBus.iAccDone  = 1'b0;
    accBus.iAccRes   = '0;
    forever begin
      @(negedge iClk);
      if (iRst) begin
        accVal          = '0;
        doneDelay       = 0;
        accBus.iAccDone = 1'b0;
        accBus.iAccRes  = '0;
      end else begin
        accBus.iAccDone = 1'b0;
        if (accBus.oAccumulate) accVal = accVal + OL'(accBus.oAccA);
        if (doneDelay > 0) begin
          doneDelay--;
          if (doneDelay == 0) begin
            accBus.iAccDone = 1'b1;
            accBus.iAccRes  = accVal;
          end
        end
        if (accBus.oTerminate) begin
          accVal    = accVal + accBias;
          doneDelay = $urandom_range(1, 3);
        end
      end
      accBus.iAccReady = accReadyRand ? ($urandom_range(0, 9) < 7) : accReadyForce;
    end
  end

  // Scoreboard monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge iClk);
      if (!iRst) begin
        if (accBus.oAccumulate || accBus.oTerminate)
          checkOutput("pulseExclusive", OL'(accBus.oAccumulate & accBus.oTerminate), '0);
        if (accBus.oAccumulate) begin
          if (expData.size() == 0) checkOutput("unexpectedAccumulate", OL'(accBus.oAccumulate), '0);
          else checkOutput("accA", OL'(accBus.oAccA), expData.pop_front());
          lastAccCyc = cyc;
        end
        if (accBus.oTerminate && checkSettle)
          checkOutput("settleGap", OL'(cyc - lastAccCyc), OL'(SETTLE + 1));
        if (oSumValid) begin
          sumCount++;
          if (prevSumValid) checkOutput("sumPulseWidth", OL'(oSumValid), '0);
          if (expSums.size() == 0) checkOutput("unexpectedSumValid", OL'(oSumValid), '0);
          else checkOutput("batchSum", oSum, expSums.pop_front());
`ifdef CSA_FEEDER_OVF_EN
          checkOutput("overflowShortBatch", OL'(oOverflow), '0);
`endif
        end
      end
      prevSumValid = oSumValid;
    end
  end

  task automatic applyStimulus(input logic [IL-1:0] data, input logic last, input int gap);
    bit accepted;
    logic rdy;
    accepted = 1'b0;
    repeat (gap) begin
      @(posedge iClk);
      #1;
    end
    iValid = 1'b1;
    iData  = data;
    iLast  = last;
    for (int k = 0; k < 300 && !accepted; k++) begin
      @(negedge iClk);
      rdy     = oReady;
      pushCyc = cyc;
      @(posedge iClk);
      #1;
      if (rdy) accepted = 1'b1;
    end
    iValid = 1'b0;
    iData  = '0;
    iLast  = 1'b0;
    checkOutput("pushAccepted", OL'(accepted), OL'(1));
    if (accepted) begin
      expData.push_back(OL'(data));
      runSum = runSum + OL'(data);
      if (last) begin
        expSums.push_back(runSum + accBias);
        runSum = '0;
      end
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 3000 && !idle; k++) begin
      @(negedge iClk);
      if (expData.size() == 0 && expSums.size() == 0 && !oBusy) idle = 1'b1;
    end
    checkOutput("drainComplete", OL'(expData.size() + expSums.size()), '0);
    @(posedge iClk);
    #1;
  endtask

  task automatic waitIssued();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge iClk);
      if (expData.size() == 0) done = 1'b1;
    end
    checkOutput("issueComplete", OL'(expData.size()), '0);
    @(posedge iClk);
    #1;
  endtask

  task automatic applyReset();
    iRst = 1'b1;
    expData.delete();
    expSums.delete();
    runSum  = '0;
    accBias = '0;
    @(posedge iClk);
    @(negedge iClk);
    checkOutput("rstReady", OL'(oReady), '0);
    checkOutput("rstAccA", OL'(accBus.oAccA), '0);
    checkOutput("rstAccumulate", OL'(accBus.oAccumulate), '0);
    checkOutput("rstTerminate", OL'(accBus.oTerminate), '0);
    checkOutput("rstSum", oSum, '0);
    checkOutput("rstSumValid", OL'(oSumValid), '0);
    checkOutput("rstBusy", OL'(oBusy), '0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    @(negedge iClk);
    checkOutput("readyLowUntilEdge", OL'(oReady), '0);
    @(negedge iClk);
    checkOutput("readyAfterReset", OL'(oReady), OL'(1));
    @(posedge iClk);
    #1;
  endtask

  initial begin
    int len;
    int sumsBefore;
    iRst   = 1'b1;
    iValid = 1'b0;
    iData  = '0;
    iLast  = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    applyReset();

    checkSettle = 1'b1;
    applyStimulus(16'd5, 1'b0, 0);
    applyStimulus(16'd7, 1'b0, 0);
    applyStimulus(16'd9, 1'b1, 0);
    waitIdle();

    applyStimulus(16'd100, 1'b0, 0);
    applyStimulus(16'd200, 1'b1, 0);
    waitIdle();

    accReadyForce = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    for (int i = 0; i < DEPTH; i++) applyStimulus(IL'(16'h40 + i), 1'b0, 0);
    @(negedge iClk);
    checkOutput("fullReady", OL'(oReady), '0);
    checkOutput("busyWithData", OL'(oBusy), OL'(1));
    @(posedge iClk);
    #1;
    iValid = 1'b1;
    iData  = 16'h48;
    iLast  = 1'b1;
    repeat (3) begin
      @(negedge iClk);
      checkOutput("holdWhileFull", OL'(oReady), '0);
      @(posedge iClk);
      #1;
    end
    iValid = 1'b0;
    accReadyForce = 1'b1;
    applyStimulus(16'h48, 1'b1, 0);
    waitIdle();
    @(negedge iClk);
    checkOutput("idleBusy", OL'(oBusy), '0);
    @(posedge iClk);
    #1;

    accBias = 32'hFFFF_FFF0 - accVal - 32'd1;
    applyStimulus(16'd1, 1'b1, 0);
    waitIdle();
    accBias = '0;
    applyStimulus(16'h10, 1'b0, 0);
    applyStimulus(16'h10, 1'b1, 0);
    waitIdle();

    checkSettle  = 1'b0;
    accReadyRand = 1'b1;
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++)
        applyStimulus(IL'($urandom), (k == len - 1), $urandom_range(0, 2));
      if (b % 3 == 2) waitIdle();
    end
    waitIdle();
    accReadyRand  = 1'b0;
    accReadyForce = 1'b1;
    checkSettle   = 1'b1;
    repeat (2) @(posedge iClk);
    #1;

    applyStimulus(16'd1, 1'b0, 0);
    applyStimulus(16'd2, 1'b1, 0);
    waitIssued();
    checkOutput("busyInSettle", OL'(oBusy), OL'(1));
    sumsBefore = sumCount;
    applyReset();
    repeat (10) @(posedge iClk);
    #1;
    checkOutput("noSumAfterReset", OL'(sumCount), OL'(sumsBefore));

    applyStimulus(16'd3, 1'b1, 0);
    waitIssued();
    checkOutput("pushToAccLatency", OL'(lastAccCyc - pushCyc), OL'(2));
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
